// File: rtl/enigma_pkg.sv
// Shared types for the enigma scheduler slice.
// Letter, rotor config and scheduler state definitions.
package enigma_pkg;

  localparam int LETTER_MAX = 25;

  typedef logic [4:0]  letter_t;
  typedef logic [8:0]  rotor_sel_t;
  typedef logic [14:0] rotor_pos_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CFG       = 3'd3,
    ST_CFG_WAIT  = 3'd4
  } sched_state_t;

  function automatic logic letter_ok(letter_t l);
    return l <= letter_t'(LETTER_MAX);
  endfunction

endpackage

// File: rtl/enigma_scheduler_fifo.sv
// letter_fifo: synchronous letter FIFO, first word valid while !empty.
// Ports: clk, rst_n, push, pop, din, dout, full, empty.
module letter_fifo
  import enigma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  letter_t din,
  output letter_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  letter_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr;
  logic          rd;

  // a push into a full FIFO still lands if the head leaves this cycle
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/enigma_scheduler.sv
// Round-robin scheduler feeding IR/keyboard letters and rotor configs to the core.
// Ports: letter/config strobes in, core handshake, strobes out, busy/count/errors.
module enigma_scheduler
  import enigma_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ir_valid_in,
  input  logic [4:0]  ir_letter_in,
  input  logic        kbd_valid_in,
  input  logic [4:0]  kbd_letter_in,
  input  logic        cfg_valid_in,
  input  logic [8:0]  cfg_select_in,
  input  logic [14:0] cfg_initial_in,
  input  logic        clr_err_in,
  input  logic        enig_ready_in,
  input  logic        enig_done_in,
  output logic        enig_valid_out,
  output logic [4:0]  enig_letter_out,
  output logic        rot_valid_out,
  output logic [8:0]  rot_select_out,
  output logic [14:0] rot_initial_out,
  output logic        src_out,
  output logic        busy_out,
  output logic [15:0] letters_done_out,
  output logic [3:0]  err_out
);
  localparam int TW = $clog2(TIMEOUT);

  sched_state_t  state;
  sched_state_t  state_nxt;
  logic [TW-1:0] timer;
  logic          rr_last;
  logic          cfg_pending;
  rotor_sel_t    sel_q;
  rotor_pos_t    init_q;

  letter_t ir_dout;
  letter_t kbd_dout;
  logic    ir_full;
  logic    ir_empty;
  logic    kbd_full;
  logic    kbd_empty;

  logic ir_good;
  logic kbd_good;
  logic bad_letter;
  logic take;
  logic grant_kbd;
  logic ir_pop;
  logic kbd_pop;
  logic go_cfg;
  logic cfg_ok;
  logic to_err;
  logic timer_hit;
  logic [3:0] new_err;

  assign ir_good    = ir_valid_in && letter_ok(ir_letter_in);
  assign kbd_good   = kbd_valid_in && letter_ok(kbd_letter_in);
  assign bad_letter = (ir_valid_in && !letter_ok(ir_letter_in)) ||
                      (kbd_valid_in && !letter_ok(kbd_letter_in));

  assign go_cfg    = (state == ST_IDLE) && cfg_pending;
  assign take      = (state == ST_IDLE) && !cfg_pending &&
                     enig_ready_in && !(ir_empty && kbd_empty);
  // rr_last=1 means keyboard went last, so IR wins a tie
  assign grant_kbd = !kbd_empty && (ir_empty || !rr_last);
  assign ir_pop    = take && !grant_kbd;
  assign kbd_pop   = take && grant_kbd;
  assign timer_hit = timer == TW'(TIMEOUT - 1);
  assign busy_out  = state != ST_IDLE;

  assign new_err = {to_err, bad_letter,
                    kbd_good && kbd_full && !kbd_pop,
                    ir_good && ir_full && !ir_pop};

  letter_fifo #(.DEPTH(DEPTH)) u_ir_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (ir_good),
    .pop   (ir_pop),
    .din   (ir_letter_in),
    .dout  (ir_dout),
    .full  (ir_full),
    .empty (ir_empty)
  );

  letter_fifo #(.DEPTH(DEPTH)) u_kbd_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (kbd_good),
    .pop   (kbd_pop),
    .din   (kbd_letter_in),
    .dout  (kbd_dout),
    .full  (kbd_full),
    .empty (kbd_empty)
  );

  always_comb begin
    state_nxt = state;
    to_err    = 1'b0;
    cfg_ok    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_cfg)    state_nxt = ST_CFG;
        else if (take) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (enig_done_in) begin
          state_nxt = ST_IDLE;
        end else if (timer_hit) begin
          to_err    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_CFG: state_nxt = ST_CFG_WAIT;
      ST_CFG_WAIT: begin
        // ready is still stale on the first cycle after the strobe
        if (enig_ready_in && timer != '0) begin
          cfg_ok    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timer_hit) begin
          to_err    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= ST_IDLE;
      timer            <= '0;
      rr_last          <= 1'b1;
      cfg_pending      <= 1'b0;
      sel_q            <= '0;
      init_q           <= '0;
      enig_valid_out   <= 1'b0;
      enig_letter_out  <= '0;
      src_out          <= 1'b0;
      rot_valid_out    <= 1'b0;
      rot_select_out   <= '0;
      rot_initial_out  <= '0;
      letters_done_out <= '0;
      err_out          <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)
        timer <= '0;
      else if (state == ST_WAIT_DONE || state == ST_CFG_WAIT)
        timer <= timer + 1'b1;

      enig_valid_out <= take;
      if (take) begin
        enig_letter_out <= grant_kbd ? kbd_dout : ir_dout;
        src_out         <= grant_kbd;
        rr_last         <= grant_kbd;
      end

      if (cfg_valid_in) begin
        sel_q  <= cfg_select_in;
        init_q <= cfg_initial_in;
      end
      if (cfg_valid_in)
        cfg_pending <= 1'b1;
      else if (state == ST_CFG)
        cfg_pending <= 1'b0;

      // a request arriving on the launch cycle is the newest one
      rot_valid_out <= go_cfg;
      if (go_cfg) begin
        rot_select_out  <= cfg_valid_in ? cfg_select_in : sel_q;
        rot_initial_out <= cfg_valid_in ? cfg_initial_in : init_q;
      end

      if (state == ST_WAIT_DONE && enig_done_in)
        letters_done_out <= letters_done_out + 1'b1;
      else if (cfg_ok)
        letters_done_out <= '0;

      err_out <= (clr_err_in ? 4'b0 : err_out) | new_err;
    end
  end

endmodule
